// File: rtl/morph_frame_ctrl.sv
// Frame-level controller for the binary morphology datapath: latches the operation
// mode at frame boundaries, tracks line/pixel geometry and times the pipeline drain.
module morph_frame_ctrl #(
  parameter logic [9:0]  IMG_HDISP = 10'd640,
  parameter logic [9:0]  IMG_VDISP = 10'd480,
  parameter logic [11:0] FLUSH_CYC = 12'd1284
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       per_frame_vsync,
  input  logic       per_frame_href,
  input  logic [2:0] cfg_mode,
  input  logic       cfg_valid,
  output logic       cfg_ready,
  output logic       erode_en,
  output logic       dilate_en,
  output logic       swap_order,
  output logic       busy,
  output logic       frame_done,
  output logic [9:0] pix_cnt,
  output logic [9:0] line_cnt,
  output logic       size_err
);

  typedef enum logic [1:0] {IDLE, ACTIVE, FLUSH} state_t;

  state_t      state, state_nxt;
  logic        vsync_d, href_d, armed;
  logic        frame_start, href_fall, cfg_acc;
  logic        pend_vld;
  logic [2:0]  pend_mode, act_mode, mode_nxt;
  logic [11:0] flush_cnt;
  logic [9:0]  line_inc;

  // Returns {erode_en, dilate_en, swap_order}
  function automatic logic [2:0] decode_en(input logic [2:0] mode);
    case (mode)
      3'b001:  decode_en = 3'b100;
      3'b010:  decode_en = 3'b010;
      3'b011:  decode_en = 3'b110;
      3'b100:  decode_en = 3'b111;
      default: decode_en = 3'b000;
    endcase
  endfunction

  // armed blocks a vsync that was already high when reset released from
  // looking like a rising edge
  assign frame_start = per_frame_vsync & ~vsync_d & armed;
  assign href_fall   = ~per_frame_href & href_d;
  assign cfg_ready   = ~pend_vld;
  assign cfg_acc     = cfg_valid & cfg_ready;
  assign mode_nxt    = pend_vld ? pend_mode : act_mode;
  assign line_inc    = line_cnt + 10'd1;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vsync_d <= 1'b0;
      href_d  <= 1'b0;
      armed   <= 1'b0;
    end else begin
      vsync_d <= per_frame_vsync;
      href_d  <= per_frame_href;
      armed   <= armed | ~per_frame_vsync;
    end
  end

  // A config accepted alongside a frame start stays pending for the next frame
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pend_vld                          <= 1'b0;
      act_mode                          <= 3'b000;
      {erode_en, dilate_en, swap_order} <= 3'b000;
    end else begin
      if (cfg_acc)
        pend_vld <= 1'b1;
      else if (frame_start)
        pend_vld <= 1'b0;
      if (frame_start) begin
        act_mode                          <= mode_nxt;
        {erode_en, dilate_en, swap_order} <= decode_en(mode_nxt);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (cfg_acc)
      pend_mode <= cfg_mode;
  end

  always_ff @(posedge clk) begin
    if (!rst_n)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    frame_done = 1'b0;
    busy       = (state == ACTIVE) || (state == FLUSH);
    case (state)
      IDLE: begin
        if (frame_start)
          state_nxt = ACTIVE;
      end
      ACTIVE: begin
        if (!frame_start && href_fall && (line_inc == IMG_VDISP))
          state_nxt = FLUSH;
      end
      FLUSH: begin
        if (frame_start) begin
          frame_done = 1'b1;
          state_nxt  = ACTIVE;
        end else if (flush_cnt == 12'd0) begin
          frame_done = 1'b1;
          state_nxt  = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pix_cnt   <= 10'd0;
      line_cnt  <= 10'd0;
      size_err  <= 1'b0;
      flush_cnt <= 12'd0;
    end else begin
      case (state)
        IDLE: begin
          if (frame_start) begin
            pix_cnt  <= 10'd0;
            line_cnt <= 10'd0;
            size_err <= 1'b0;
          end
        end
        ACTIVE: begin
          if (frame_start) begin
            // early vsync: the truncated frame is flagged, not cleared
            pix_cnt  <= 10'd0;
            line_cnt <= 10'd0;
            size_err <= 1'b1;
          end else if (href_fall) begin
            if (pix_cnt != IMG_HDISP)
              size_err <= 1'b1;
            line_cnt <= line_inc;
            pix_cnt  <= 10'd0;
            if (line_inc == IMG_VDISP)
              flush_cnt <= FLUSH_CYC;
          end else if (per_frame_href && (pix_cnt != 10'h3FF)) begin
            pix_cnt <= pix_cnt + 10'd1;
          end
        end
        FLUSH: begin
          if (frame_start) begin
            pix_cnt  <= 10'd0;
            line_cnt <= 10'd0;
            size_err <= 1'b0;
          end else begin
            if (flush_cnt != 12'd0)
              flush_cnt <= flush_cnt - 12'd1;
            if (per_frame_href)
              size_err <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_morph_frame_ctrl.sv
// Directed bench for morph_frame_ctrl using a reduced frame geometry.
module tb_morph_frame_ctrl;

  localparam logic [9:0]  H = 10'd12;
  localparam logic [9:0]  V = 10'd8;
  localparam logic [11:0] F = 12'd30;

  logic       clk = 1'b0;
  logic       rst_n, vsync, href, cfg_valid;
  logic [2:0] cfg_mode;
  logic       cfg_ready, erode_en, dilate_en, swap_order, busy, frame_done, size_err;
  logic [9:0] pix_cnt, line_cnt;
  int         errors = 0;
  int         checks = 0;
  int         k_first, pulses;

  always #5 clk = ~clk;

  morph_frame_ctrl #(.IMG_HDISP(H), .IMG_VDISP(V), .FLUSH_CYC(F)) dut (
    .clk(clk), .rst_n(rst_n), .per_frame_vsync(vsync), .per_frame_href(href),
    .cfg_mode(cfg_mode), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .erode_en(erode_en), .dilate_en(dilate_en), .swap_order(swap_order),
    .busy(busy), .frame_done(frame_done), .pix_cnt(pix_cnt), .line_cnt(line_cnt),
    .size_err(size_err)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic drive_line(input int n);
    href = 1'b1;
    for (int i = 0; i < n; i++) step();
    href = 1'b0;
    step();
  endtask

  task automatic run_lines(input int n);
    for (int l = 0; l < n; l++) begin
      if (l > 0) idle(2);
      drive_line(int'(H));
    end
  endtask

  task automatic wait_done(output int first, output int cnt);
    first = -1;
    cnt   = 0;
    for (int k = 0; k < int'(F) + 10; k++) begin
      #1;
      if (frame_done) begin
        if (first < 0) first = k;
        cnt++;
      end
      step();
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; vsync = 1'b0; href = 1'b0; cfg_valid = 1'b0; cfg_mode = 3'b000;
    idle(3);
    checks++;
    if ({cfg_ready, busy, erode_en, dilate_en, swap_order, frame_done, size_err} !== 7'b1000000) begin
      errors++; $display("FAIL reset_flags: got %b expected 1000000",
        {cfg_ready, busy, erode_en, dilate_en, swap_order, frame_done, size_err});
    end
    checks++;
    if ({pix_cnt, line_cnt} !== 20'd0) begin
      errors++; $display("FAIL reset_counts: got pix=%0d line=%0d expected 0/0", pix_cnt, line_cnt);
    end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_cfg_open();
    cfg_mode = 3'b011; cfg_valid = 1'b1;
    step();
    cfg_mode = 3'b010;
    step();
    cfg_valid = 1'b0;
    checks++;
    if (cfg_ready !== 1'b0) begin
      errors++; $display("FAIL cfg_ready_pending: got %b expected 0", cfg_ready);
    end
    checks++;
    if ({erode_en, dilate_en, swap_order} !== 3'b000) begin
      errors++; $display("FAIL en_before_frame: got %b expected 000", {erode_en, dilate_en, swap_order});
    end
    vsync = 1'b1;
    step();
    vsync = 1'b0;
    checks++;
    if (cfg_ready !== 1'b1) begin
      errors++; $display("FAIL cfg_ready_return: got %b expected 1", cfg_ready);
    end
    checks++;
    if ({erode_en, dilate_en, swap_order, busy} !== 4'b1101) begin
      errors++; $display("FAIL en_open: got %b expected 1101", {erode_en, dilate_en, swap_order, busy});
    end
  endtask

  task automatic test_full_frame();
    drive_line(int'(H));
    checks++;
    if ({line_cnt, pix_cnt, size_err} !== {10'd1, 10'd0, 1'b0}) begin
      errors++; $display("FAIL first_line: got line=%0d pix=%0d err=%b expected 1/0/0", line_cnt, pix_cnt, size_err);
    end
    idle(2);
    href = 1'b1;
    idle(5);
    checks++;
    if (pix_cnt !== 10'd5) begin
      errors++; $display("FAIL pix_mid_line: got %0d expected 5", pix_cnt);
    end
    idle(int'(H) - 5);
    href = 1'b0;
    step();
    for (int l = 2; l < int'(V); l++) begin
      idle(2);
      drive_line(int'(H));
    end
    checks++;
    if ({busy, line_cnt, size_err} !== {1'b1, V, 1'b0}) begin
      errors++; $display("FAIL frame_end: got busy=%b line=%0d err=%b expected 1/%0d/0", busy, line_cnt, size_err, V);
    end
    wait_done(k_first, pulses);
    checks++;
    if (k_first !== int'(F) || pulses !== 1) begin
      errors++; $display("FAIL flush_len: got at=%0d pulses=%0d expected at=%0d pulses=1", k_first, pulses, F);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL busy_after_done: got %b expected 0", busy);
    end
  endtask

  task automatic test_short_line();
    href = 1'b1;
    idle(3);
    href = 1'b0;
    idle(2);
    checks++;
    if ({pix_cnt, line_cnt} !== {10'd0, V}) begin
      errors++; $display("FAIL idle_hold: got pix=%0d line=%0d expected 0/%0d", pix_cnt, line_cnt, V);
    end
    vsync = 1'b1; step(); vsync = 1'b0;
    checks++;
    if ({line_cnt, size_err} !== {10'd0, 1'b0}) begin
      errors++; $display("FAIL start_clear: got line=%0d err=%b expected 0/0", line_cnt, size_err);
    end
    drive_line(int'(H) - 1);
    checks++;
    if (size_err !== 1'b1) begin
      errors++; $display("FAIL short_line_err: got %b expected 1", size_err);
    end
    for (int l = 1; l < int'(V); l++) begin
      idle(2);
      drive_line(int'(H));
    end
    wait_done(k_first, pulses);
    checks++;
    if (size_err !== 1'b1 || k_first !== int'(F)) begin
      errors++; $display("FAIL err_sticky: got err=%b done_at=%0d expected 1/%0d", size_err, k_first, F);
    end
    vsync = 1'b1; step(); vsync = 1'b0;
    checks++;
    if (size_err !== 1'b0) begin
      errors++; $display("FAIL err_clear_next: got %b expected 0", size_err);
    end
  endtask

  task automatic test_early_vsync();
    for (int l = 0; l < 3; l++) begin
      drive_line(int'(H));
      idle(2);
    end
    checks++;
    if (line_cnt !== 10'd3) begin
      errors++; $display("FAIL line_before_early: got %0d expected 3", line_cnt);
    end
    vsync = 1'b1; step(); vsync = 1'b0;
    checks++;
    if ({size_err, busy, line_cnt, pix_cnt} !== {1'b1, 1'b1, 10'd0, 10'd0}) begin
      errors++; $display("FAIL early_vsync: got err=%b busy=%b line=%0d pix=%0d expected 1/1/0/0", size_err, busy, line_cnt, pix_cnt);
    end
    run_lines(int'(V));
    idle(5);
    vsync = 1'b1;
    #1;
    checks++;
    if (frame_done !== 1'b1) begin
      errors++; $display("FAIL done_on_abort: got %b expected 1", frame_done);
    end
    step();
    vsync = 1'b0;
    #1;
    checks++;
    if ({frame_done, busy, size_err, line_cnt} !== {1'b0, 1'b1, 1'b0, 10'd0}) begin
      errors++; $display("FAIL after_abort: got done=%b busy=%b err=%b line=%0d expected 0/1/0/0", frame_done, busy, size_err, line_cnt);
    end
    run_lines(int'(V));
    checks++;
    if (size_err !== 1'b0) begin
      errors++; $display("FAIL clean_frame: got %b expected 0", size_err);
    end
    href = 1'b1; step(); href = 1'b0;
    checks++;
    if ({size_err, pix_cnt} !== {1'b1, 10'd0}) begin
      errors++; $display("FAIL href_in_flush: got err=%b pix=%0d expected 1/0", size_err, pix_cnt);
    end
    wait_done(k_first, pulses);
    checks++;
    if (k_first !== int'(F) - 1 || pulses !== 1) begin
      errors++; $display("FAIL flush_len_href: got at=%0d pulses=%0d expected at=%0d pulses=1", k_first, pulses, int'(F) - 1);
    end
  endtask

  task automatic test_same_cycle_cfg();
    idle(2);
    cfg_mode = 3'b100; cfg_valid = 1'b1; vsync = 1'b1;
    step();
    cfg_valid = 1'b0; vsync = 1'b0;
    checks++;
    if ({erode_en, dilate_en, swap_order, cfg_ready, busy} !== 5'b11001) begin
      errors++; $display("FAIL en_keep_old: got %b expected 11001", {erode_en, dilate_en, swap_order, cfg_ready, busy});
    end
    idle(3);
    vsync = 1'b1; step(); vsync = 1'b0;
    checks++;
    if ({erode_en, dilate_en, swap_order, cfg_ready} !== 4'b1111) begin
      errors++; $display("FAIL en_close: got %b expected 1111", {erode_en, dilate_en, swap_order, cfg_ready});
    end
  endtask

  task automatic test_decode();
    logic [2:0] modes [5];
    logic [2:0] exps  [5];
    modes = '{3'b001, 3'b010, 3'b000, 3'b101, 3'b011};
    exps  = '{3'b100, 3'b010, 3'b000, 3'b000, 3'b110};
    for (int i = 0; i < 5; i++) begin
      cfg_mode = modes[i]; cfg_valid = 1'b1;
      step();
      cfg_valid = 1'b0;
      idle(1);
      vsync = 1'b1; step(); vsync = 1'b0;
      checks++;
      if ({erode_en, dilate_en, swap_order} !== exps[i]) begin
        errors++; $display("FAIL decode_%0d: got %b expected %b", i, {erode_en, dilate_en, swap_order}, exps[i]);
      end
      idle(1);
    end
  endtask

  task automatic test_sat();
    vsync = 1'b1; step(); vsync = 1'b0;
    href = 1'b1;
    idle(1030);
    checks++;
    if (pix_cnt !== 10'd1023) begin
      errors++; $display("FAIL pix_saturate: got %0d expected 1023", pix_cnt);
    end
    href = 1'b0;
    step();
    checks++;
    if ({pix_cnt, line_cnt} !== {10'd0, 10'd1}) begin
      errors++; $display("FAIL sat_line_end: got pix=%0d line=%0d expected 0/1", pix_cnt, line_cnt);
    end
  endtask

  task automatic test_reset_mid();
    idle(1);
    vsync = 1'b1;
    step();
    cfg_mode = 3'b001; cfg_valid = 1'b1;
    step();
    cfg_valid = 1'b0; href = 1'b1;
    idle(3);
    rst_n = 1'b0;
    pulses = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      if (frame_done) pulses++;
    end
    checks++;
    if (pulses !== 0) begin
      errors++; $display("FAIL done_in_reset: got %0d pulses expected 0", pulses);
    end
    checks++;
    if ({cfg_ready, busy, erode_en, dilate_en, swap_order, frame_done, size_err, pix_cnt, line_cnt} !== {7'b1000000, 20'd0}) begin
      errors++; $display("FAIL reset_mid: got %b expected %b",
        {cfg_ready, busy, erode_en, dilate_en, swap_order, frame_done, size_err, pix_cnt, line_cnt}, {7'b1000000, 20'd0});
    end
    rst_n = 1'b1; href = 1'b0;
    idle(4);
    checks++;
    if ({busy, cfg_ready} !== 2'b01) begin
      errors++; $display("FAIL no_start_vsync_high: got busy=%b ready=%b expected 0/1", busy, cfg_ready);
    end
    vsync = 1'b0; step();
    vsync = 1'b1; step(); vsync = 1'b0;
    checks++;
    if ({busy, erode_en, dilate_en, swap_order} !== 4'b1000) begin
      errors++; $display("FAIL start_after_reset: got %b expected 1000", {busy, erode_en, dilate_en, swap_order});
    end
  endtask

  initial begin
    test_reset();
    test_cfg_open();
    test_full_frame();
    test_short_line();
    test_early_vsync();
    test_same_cycle_cfg();
    test_decode();
    test_sat();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not complete, checks=%0d", checks);
    $fatal(1);
  end

endmodule
